// File: rtl/prog_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : prog_feeder
//  Purpose  : Holds a small 32 x 9 program and feeds it, one instruction at a
//             time, to a simple processor. Each instruction is presented on
//             DOUT with a one-cycle Run strobe. The feeder then waits for the
//             processor's Done flag, advancing PC by 1 (or by 2 for mvi, whose
//             immediate follows the opcode word). Execution stops on a HALT
//             opcode, or on a watchdog timeout if Done never arrives.
//  Ports    : Clock, Resetn    - clock (rising edge), async active-low reset
//             Start            - run the program from address 0 (idle states)
//             LdEn/LdAddr/LdData - program-memory write port (idle states)
//             Done             - processor instruction-complete flag
//             DOUT             - word presented to the processor DIN bus
//             Run              - one-cycle instruction start strobe
//             PC               - address of the current instruction
//             Busy             - program executing (ISSUE or WAIT)
//             Halted / Err     - HALT reached / watchdog timeout
//             InstrCnt         - completed instructions, saturating at 255
//  Revision : 1.0  initial release
// ============================================================================
module prog_feeder #(
  parameter int WDOG = 8
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       Start,
  input  logic       LdEn,
  input  logic [4:0] LdAddr,
  input  logic [8:0] LdData,
  input  logic       Done,
  output logic [8:0] DOUT,
  output logic       Run,
  output logic [4:0] PC,
  output logic       Busy,
  output logic       Halted,
  output logic       Err,
  output logic [7:0] InstrCnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_HALT  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_HALT = 3'b111;

  // The watchdog only needs to count up to WDOG-1: the WDOG-th silent WAIT
  // cycle is recognised by the terminal count itself.
  localparam int             WD_W    = (WDOG < 2) ? 1 : $clog2(WDOG);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG - 1);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t          r_state;
  logic [4:0]      r_pc;
  logic [7:0]      r_cnt;
  logic [2:0]      r_op;
  logic [WD_W-1:0] r_wdog;
  logic [8:0]      r_mem [0:31];

  state_t          w_state_nx;
  logic [4:0]      w_pc_nx;
  logic [7:0]      w_cnt_nx;
  logic [2:0]      w_op_nx;
  logic [WD_W-1:0] w_wdog_nx;

  logic            w_idle_like;
  logic            w_wr_ok;
  logic [8:0]      w_cur;
  logic [8:0]      w_nxt;
  logic            w_lat_mvi;

  // Loading is only allowed while nothing is executing, so the processor can
  // never observe a word changing under it.
  assign w_idle_like = (r_state == S_IDLE) || (r_state == S_HALT) || (r_state == S_ERR);
  assign w_wr_ok     = LdEn && w_idle_like;

  // Asynchronous reads: the word at PC and the one after it (mvi immediate).
  // The 5-bit add wraps 31 -> 0 naturally.
  assign w_cur     = r_mem[r_pc];
  assign w_nxt     = r_mem[r_pc + 5'd1];
  assign w_lat_mvi = (r_op == OP_MVI);

  // --------------------------------------------------------------------------
  // Program memory: write-only clocked, contents survive reset.
  // --------------------------------------------------------------------------
  always_ff @(posedge Clock) begin
    if (w_wr_ok) begin
      r_mem[LdAddr] <= LdData;
    end
  end

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= S_IDLE;
      r_pc    <= 5'd0;
      r_cnt   <= 8'd0;
      r_op    <= 3'd0;
      r_wdog  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_pc    <= w_pc_nx;
      r_cnt   <= w_cnt_nx;
      r_op    <= w_op_nx;
      r_wdog  <= w_wdog_nx;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output logic. All outputs are decoded from the current
  // state, so an asynchronous reset clears them immediately.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nx = r_state;
    w_pc_nx    = r_pc;
    w_cnt_nx   = r_cnt;
    w_op_nx    = r_op;
    w_wdog_nx  = r_wdog;
    DOUT       = 9'd0;
    Run        = 1'b0;
    Busy       = 1'b0;
    Halted     = 1'b0;
    Err        = 1'b0;

    case (r_state)
      S_IDLE, S_HALT, S_ERR: begin
        Halted = (r_state == S_HALT);
        Err    = (r_state == S_ERR);
        if (Start) begin
          w_state_nx = S_ISSUE;
          w_pc_nx    = 5'd0;
          w_cnt_nx   = 8'd0;
          w_wdog_nx  = '0;
        end
      end

      S_ISSUE: begin
        Busy = 1'b1;
        if (w_cur[8:6] == OP_HALT) begin
          // HALT is never presented to the processor.
          w_state_nx = S_HALT;
        end else begin
          DOUT       = w_cur;
          Run        = 1'b1;
          w_op_nx    = w_cur[8:6];
          w_wdog_nx  = '0;
          w_state_nx = S_WAIT;
        end
      end

      S_WAIT: begin
        Busy = 1'b1;
        // During an mvi the processor fetches its immediate from DIN.
        DOUT = w_lat_mvi ? w_nxt : w_cur;
        if (Done) begin
          w_pc_nx    = w_lat_mvi ? (r_pc + 5'd2) : (r_pc + 5'd1);
          w_cnt_nx   = (r_cnt == 8'hFF) ? r_cnt : (r_cnt + 8'd1);
          w_wdog_nx  = '0;
          w_state_nx = S_ISSUE;
        end else if (r_wdog == WD_LAST) begin
          w_wdog_nx  = '0;
          w_state_nx = S_ERR;
        end else begin
          w_wdog_nx  = r_wdog + 1'b1;
        end
      end

      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  assign PC       = r_pc;
  assign InstrCnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_prog_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prog_feeder
//  Purpose  : Self-checking bench for prog_feeder. The bench plays the role of
//             the processor: it interprets the loaded program instruction by
//             instruction (one or two words, HALT, wrap-around addressing),
//             chooses when to raise Done, and predicts every cycle's outputs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_prog_feeder;

  localparam int WDOG = 8;

  logic       Clock = 1'b0;
  logic       Resetn;
  logic       Start;
  logic       LdEn;
  logic [4:0] LdAddr;
  logic [8:0] LdData;
  logic       Done;
  logic [8:0] DOUT;
  logic       Run;
  logic [4:0] PC;
  logic       Busy;
  logic       Halted;
  logic       Err;
  logic [7:0] InstrCnt;

  prog_feeder #(.WDOG(WDOG)) dut (
    .Clock    (Clock),
    .Resetn   (Resetn),
    .Start    (Start),
    .LdEn     (LdEn),
    .LdAddr   (LdAddr),
    .LdData   (LdData),
    .Done     (Done),
    .DOUT     (DOUT),
    .Run      (Run),
    .PC       (PC),
    .Busy     (Busy),
    .Halted   (Halted),
    .Err      (Err),
    .InstrCnt (InstrCnt)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  int chk_cnt = 0;
  int err_cnt = 0;

  // Reference program image and run results.
  logic [8:0] mem_m [32];
  int         dq [$];      // per-instruction Done delay; 0 = never (timeout)
  int         runq [$];    // cycle stamps of Run pulses
  int         m_pc;
  int         m_cnt;
  int         halt_issue_cyc;
  int         t0;

  localparam logic [8:0] W_HALT = 9'b111_000_000;
  localparam logic [8:0] W_MVI  = 9'b001_000_000;
  localparam logic [8:0] W_ADD  = 9'b010_000_001;
  localparam logic [8:0] W_SUB  = 9'b011_001_000;
  localparam logic [8:0] W_MV   = 9'b000_010_001;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic chk_rest(input string tag, input bit hl, input bit er, input int pc, input int cnt);
    chk({tag, "_busy"},   Busy,     0);
    chk({tag, "_run"},    Run,      0);
    chk({tag, "_dout"},   DOUT,     0);
    chk({tag, "_halted"}, Halted,   hl);
    chk({tag, "_err"},    Err,      er);
    chk({tag, "_pc"},     PC,       pc);
    chk({tag, "_cnt"},    InstrCnt, cnt);
  endtask

  task automatic load(input int a, input logic [8:0] d);
    LdEn   = 1'b1;
    LdAddr = 5'(a);
    LdData = d;
    tick();
    LdEn   = 1'b0;
    mem_m[a] = d;
  endtask

  function automatic logic [8:0] rand_word(input int halt_pct);
    logic [8:0] w;
    w = 9'($urandom);
    if (int'($urandom_range(0, 99)) < halt_pct) w[8:6] = 3'b111;
    else w[8:6] = 3'($urandom_range(0, 6));
    return w;
  endfunction

  // Start the program and follow it to HALT or watchdog timeout.
  //   budget   : after this many completed instructions force a timeout
  //   allow_to : random Done delays may include a timeout
  //   noise    : random Start/LdEn/Done where they must be ignored
  //   do_ld    : perform a write in the same cycle as Start
  task automatic run_prog(input int budget, input bit allow_to, input bit noise,
                          input bit do_ld, input int ld_a, input logic [8:0] ld_d);
    logic [8:0] word;
    logic [8:0] exp_dout;
    bit         mvi;
    int         k;
    int         waits;
    int         pc;
    int         cnt;
    int         n;
    runq.delete();
    Start = 1'b1;
    if (do_ld) begin
      LdEn = 1'b1; LdAddr = 5'(ld_a); LdData = ld_d;
      mem_m[ld_a] = ld_d;
    end
    t0 = cyc;
    tick();
    Start = 1'b0;
    LdEn  = 1'b0;
    pc = 0; cnt = 0; n = 0;
    forever begin
      word = mem_m[pc];
      chk("issue_busy", Busy, 1);
      chk("issue_pc", PC, pc);
      chk("issue_cnt", InstrCnt, cnt);
      if (noise) begin
        Done = 1'($urandom); Start = 1'($urandom);
        LdEn = 1'($urandom); LdAddr = 5'($urandom); LdData = 9'($urandom);
      end
      if (word[8:6] == 3'b111) begin
        chk("halt_run", Run, 0);
        halt_issue_cyc = cyc;
        tick();
        Done = 1'b0; Start = 1'b0; LdEn = 1'b0;
        chk_rest("halt", 1, 0, pc, cnt);
        break;
      end
      chk("issue_run", Run, 1);
      chk("issue_dout", DOUT, word);
      runq.push_back(cyc);
      if (dq.size() > 0)                         k = dq.pop_front();
      else if (n >= budget)                      k = 0;
      else if (allow_to && $urandom_range(0, 9) == 0) k = 0;
      else                                       k = $urandom_range(1, WDOG);
      tick();
      mvi      = (word[8:6] == 3'b001);
      exp_dout = mvi ? mem_m[(pc + 1) % 32] : word;
      waits    = (k == 0) ? WDOG : k;
      for (int i = 1; i <= waits; i++) begin
        chk("wait_run", Run, 0);
        chk("wait_busy", Busy, 1);
        chk("wait_dout", DOUT, exp_dout);
        chk("wait_pc", PC, pc);
        Done  = (i == k);
        Start = noise ? 1'($urandom) : 1'b0;
        LdEn  = noise ? 1'($urandom) : 1'b0;
        LdAddr = 5'($urandom); LdData = 9'($urandom);
        tick();
      end
      Done = 1'b0; Start = 1'b0; LdEn = 1'b0;
      if (k == 0) begin
        chk_rest("wdog", 0, 1, pc, cnt);
        break;
      end
      pc  = (pc + (mvi ? 2 : 1)) % 32;
      cnt = (cnt < 255) ? cnt + 1 : 255;
      n++;
    end
    m_pc  = pc;
    m_cnt = cnt;
  endtask

  initial begin
    Resetn = 1'b0; Start = 1'b0; LdEn = 1'b0; LdAddr = '0; LdData = '0; Done = 1'b0;
    repeat (2) @(negedge Clock);
    chk_rest("reset", 0, 0, 0, 0);
    Resetn = 1'b1;
    @(negedge Clock);
    for (int a = 0; a < 32; a++) load(a, rand_word(0));

    // Two-word mvi then HALT.
    load(0, W_MVI); load(1, 9'd5); load(2, W_HALT);
    dq = '{1};
    run_prog(100, 0, 0, 0, 0, 0);
    chk("mvi_run_lat", runq[0] - t0, 1);
    chk("mvi_pc", PC, 2);
    chk("mvi_cnt", InstrCnt, 1);

    // add/sub/mv spacing.
    load(0, W_ADD); load(1, W_SUB); load(2, W_MV); load(3, W_HALT);
    dq = '{3, 3, 1};
    run_prog(100, 0, 0, 0, 0, 0);
    chk("sp_add", runq[1] - runq[0], 4);
    chk("sp_sub", runq[2] - runq[1], 4);
    chk("sp_mv", halt_issue_cyc - runq[2], 2);
    chk("sp_cnt", InstrCnt, 3);
    chk("sp_pc", PC, 3);

    // Watchdog, then restart from ERR (load while in ERR).
    dq = '{0};
    run_prog(100, 0, 0, 0, 0, 0);
    load(0, W_HALT);
    run_prog(100, 0, 0, 0, 0, 0);
    chk("restart_pc", PC, 0);

    // mvi at 31 with immediate at 0, wrap to 1.
    for (int a = 0; a < 31; a++) load(a, W_MV ^ 9'(a));
    load(31, W_MVI);
    dq.delete();
    for (int i = 0; i < 32; i++) dq.push_back(1);
    dq.push_back(0);
    run_prog(100, 0, 0, 0, 0, 0);
    chk("wrap_pc", PC, 1);
    chk("wrap_cnt", InstrCnt, 32);

    // Write in the Start cycle is seen by the first ISSUE.
    run_prog(100, 1, 0, 1, 0, W_HALT);
    chk("ldstart_halted", Halted, 1);

    // Asynchronous reset mid-WAIT, then identical rerun.
    load(0, W_MVI); load(1, 9'h0AB); load(2, W_ADD); load(3, W_HALT);
    Start = 1'b1; tick(); Start = 1'b0;
    tick(); Done = 1'b1; tick(); Done = 1'b0;
    tick();
    chk("pre_rst_pc", PC, 2);
    chk("pre_rst_busy", Busy, 1);
    #2 Resetn = 1'b0;
    #1;
    chk("arst_dout", DOUT, 0);
    chk("arst_run", Run, 0);
    chk("arst_busy", Busy, 0);
    chk("arst_pc", PC, 0);
    chk("arst_cnt", InstrCnt, 0);
    chk("arst_halted", Halted, 0);
    chk("arst_err", Err, 0);
    @(negedge Clock);
    Resetn = 1'b1;
    @(negedge Clock);
    chk_rest("post_rst", 0, 0, 0, 0);
    dq = '{1, 2};
    run_prog(100, 0, 0, 0, 0, 0);
    chk("rerun_pc", PC, 3);
    chk("rerun_cnt", InstrCnt, 2);

    // Saturating instruction count on a program with no HALT.
    for (int a = 0; a < 32; a++) load(a, rand_word(0));
    dq.delete();
    run_prog(260, 0, 1, 0, 0, 0);
    chk("sat_cnt", InstrCnt, 255);

    // Random programs with ignored-input noise.
    for (int it = 0; it < 20; it++) begin
      for (int a = 0; a < 32; a++) load(a, rand_word(15));
      dq.delete();
      run_prog(25, 1, 1, 1'($urandom), $urandom_range(0, 31), rand_word(20));
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
`default_nettype wire
